// File: rtl/recall_pkg.sv
// Shared types and constants for the memory-game recall checker.
// Pointer width covers 0..16 inclusive so a full buffer is distinguishable from empty.
package recall_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int DW_DEFAULT    = 4;
    localparam int PTR_W         = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RECALL  = 2'd2,
        VERDICT = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] to_ptr(input int value);
        logic [31:0] v;
        v = value;
        return v[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/recall_mem.sv
// Small register file holding the flashed digits: synchronous write, combinational read.
// Addresses are full pointer width; reads at or beyond DEPTH return zero.
module recall_mem
    import recall_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [DW-1:0]    rd_data
);

    logic [DEPTH*DW-1:0] rows_flat;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
            logic          row_we;
            logic [DW-1:0] row_reg;

            assign row_we = wr_en && (wr_addr == to_ptr(gi));

            always_ff @(posedge clock) begin
                if (row_we) begin
                    row_reg <= wr_data;
                end
            end

            assign rows_flat[gi*DW +: DW] = row_reg;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == to_ptr(i)) begin
                rd_data = rows_flat[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/recall_checker.sv
// Captures the flashed digit sequence, then checks the player's answers in order
// and emits a one-cycle win or loose verdict. All outputs are registered.
module recall_checker
    import recall_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          logout_pulse,
    input  logic          flash_valid,
    input  logic [DW-1:0] flash_digit,
    input  logic          flash_done,
    input  logic          answer_pulse,
    input  logic [DW-1:0] answer_in,
    input  logic          time_stop,
    output logic          win,
    output logic          loose,
    output logic [DW-1:0] seg_in_ans,
    output logic [4:0]    progress,
    output logic          recall_active,
    output logic          overflow
);

    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    state_t           state_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] progress_reg;
    logic [DW-1:0]    seg_reg;
    logic             win_reg;
    logic             loose_reg;
    logic             active_reg;
    logic             overflow_reg;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [DW-1:0]    expected_digit;
    logic             buf_full;
    logic             answer_match;
    logic             last_digit;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] progress_next;

    assign buf_full      = (wr_ptr_reg == DEPTH_PTR);
    assign answer_match  = (answer_in == expected_digit);
    assign rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
    assign wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
    assign progress_next = progress_reg + PTR_W'(1);
    assign last_digit    = (rd_ptr_next == wr_ptr_reg);

    // The first digit of a round lands at address 0 straight from IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_reg;
        if (!rst && !logout_pulse && flash_valid) begin
            case (state_reg)
                IDLE: begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                end
                CAPTURE: begin
                    mem_we    = !buf_full;
                end
                default: begin
                    mem_we    = 1'b0;
                end
            endcase
        end
    end

    recall_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (flash_digit),
        .rd_addr (rd_ptr_reg),
        .rd_data (expected_digit)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            progress_reg <= '0;
            seg_reg      <= '0;
            win_reg      <= 1'b0;
            loose_reg    <= 1'b0;
            active_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            win_reg   <= 1'b0;
            loose_reg <= 1'b0;
            if (logout_pulse) begin
                state_reg    <= IDLE;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                progress_reg <= '0;
                overflow_reg <= 1'b0;
                active_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (flash_valid) begin
                            wr_ptr_reg   <= PTR_W'(1);
                            rd_ptr_reg   <= '0;
                            progress_reg <= '0;
                            overflow_reg <= 1'b0;
                            state_reg    <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (flash_valid) begin
                            if (buf_full) begin
                                overflow_reg <= 1'b1;
                            end else begin
                                wr_ptr_reg <= wr_ptr_next;
                            end
                        end
                        // A digit arriving with flash_done is already counted above.
                        if (flash_done && (wr_ptr_reg != '0)) begin
                            rd_ptr_reg <= '0;
                            active_reg <= 1'b1;
                            state_reg  <= RECALL;
                        end
                    end
                    RECALL: begin
                        if (time_stop) begin
                            loose_reg  <= 1'b1;
                            active_reg <= 1'b0;
                            state_reg  <= VERDICT;
                        end else if (answer_pulse) begin
                            if (answer_match) begin
                                seg_reg      <= answer_in;
                                rd_ptr_reg   <= rd_ptr_next;
                                progress_reg <= progress_next;
                                if (last_digit) begin
                                    win_reg    <= 1'b1;
                                    active_reg <= 1'b0;
                                    state_reg  <= VERDICT;
                                end
                            end else begin
                                loose_reg  <= 1'b1;
                                active_reg <= 1'b0;
                                state_reg  <= VERDICT;
                            end
                        end
                    end
                    VERDICT: begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        state_reg  <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign win           = win_reg;
    assign loose         = loose_reg;
    assign seg_in_ans    = seg_reg;
    assign progress      = progress_reg;
    assign recall_active = active_reg;
    assign overflow      = overflow_reg;

endmodule
